spad_seq_ctrl: RTL and testbench

Sequencer that drives the write and read ports of a processing-element register scratchpad. It loads a burst of operands from an upstream valid/ready stream into the scratchpad. It then streams them back in address order to the MAC datapath over a downstream valid/ready interface. It sits between the PE input network and the scratchpad/MAC pair, and is the only master of the scratchpad address and write-enable pins.

---
 rtl/spad_seq_ctrl_if.sv | 72 +++++++
 rtl/spad_seq_ctrl.sv | 116 +++++++++++
 tb/tb_spad_seq_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spad_seq_ctrl_if.sv
// Handshake and scratchpad bus bundle for spad_seq_ctrl.
// master: the sequencer itself. slave: the surrounding PE network, scratchpad and MAC.
// Optional macro SPAD_SEQ_REUSE_EN adds the passes request field.
interface spad_seq_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REGS   = 9,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
);
   logic                  start;
   logic [ADDR_WIDTH:0]   len;
`ifdef SPAD_SEQ_REUSE_EN
   logic [3:0]            passes;
`endif
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  spad_wen;
   logic [ADDR_WIDTH-1:0] spad_waddr;
   logic [DATA_WIDTH-1:0] spad_din;
   logic [ADDR_WIDTH-1:0] spad_raddr;
   logic [DATA_WIDTH-1:0] spad_dout;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   modport master (
      input  start,
      input  len,
`ifdef SPAD_SEQ_REUSE_EN
      input  passes,
`endif
      input  in_valid,
      input  in_data,
      input  spad_dout,
      input  out_ready,
      output in_ready,
      output spad_wen,
      output spad_waddr,
      output spad_din,
      output spad_raddr,
      output out_valid,
      output out_data,
      output out_last,
      output busy,
      output done
   );

   modport slave (
      output start,
      output len,
`ifdef SPAD_SEQ_REUSE_EN
      output passes,
`endif
      output in_valid,
      output in_data,
      output spad_dout,
      output out_ready,
      input  in_ready,
      input  spad_wen,
      input  spad_waddr,
      input  spad_din,
      input  spad_raddr,
      input  out_valid,
      input  out_data,
      input  out_last,
      input  busy,
      input  done
   );
endinterface

// File: rtl/spad_seq_ctrl.sv
// Scratchpad load-then-drain sequencer.
// Loads up to NUM_REGS operands from the upstream stream, then replays them in address order
// to the MAC. Optional macro SPAD_SEQ_REUSE_EN replays the burst 'passes' times.
module spad_seq_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REGS   = 9,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rstn,
   spad_seq_ctrl_if.master bus
);
   typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

   localparam logic [ADDR_WIDTH:0] MaxLen = (ADDR_WIDTH + 1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH:0] One    = (ADDR_WIDTH + 1)'(1);

   state_e                state;
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   len_r;

   logic [ADDR_WIDTH:0]   len_clamp;
   logic [ADDR_WIDTH:0]   idx_last;
   logic                  wr_end;
   logic                  rd_end;
   logic                  final_pass;
   logic                  in_hs;
   logic                  out_hs;

`ifdef SPAD_SEQ_REUSE_EN
   logic [3:0] passes_r;
   logic [3:0] pass_cnt;
   assign final_pass = (pass_cnt == passes_r - 4'd1);
`else
   assign final_pass = 1'b1;
`endif

   assign len_clamp = (bus.len > MaxLen) ? MaxLen : bus.len;
   assign idx_last  = len_r - One;
   assign wr_end    = ({1'b0, wptr} == idx_last);
   assign rd_end    = ({1'b0, rptr} == idx_last);
   assign in_hs     = (state == StFill) && bus.in_valid;
   assign out_hs    = (state == StDrain) && bus.out_ready;

   // Sequencer state, pointers and job length.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= StIdle;
         wptr  <= '0;
         rptr  <= '0;
         len_r <= '0;
`ifdef SPAD_SEQ_REUSE_EN
         passes_r <= '0;
         pass_cnt <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.start && (bus.len != '0)) begin
                  state <= StFill;
                  len_r <= len_clamp;
                  wptr  <= '0;
`ifdef SPAD_SEQ_REUSE_EN
                  passes_r <= (bus.passes == 4'd0) ? 4'd1 : bus.passes;
                  pass_cnt <= '0;
`endif
               end
            end
            StFill: begin
               if (in_hs) begin
                  if (wr_end) begin
                     state <= StDrain;
                     rptr  <= '0;
                  end else begin
                     wptr <= wptr + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (out_hs) begin
                  if (rd_end && final_pass) begin
                     // rptr parks on the last address so raddr holds while idle.
                     state <= StDone;
                  end else if (rd_end) begin
                     rptr <= '0;
`ifdef SPAD_SEQ_REUSE_EN
                     pass_cnt <= pass_cnt + 4'd1;
`endif
                  end else begin
                     rptr <= rptr + 1'b1;
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Port decode from the registered state; data paths are gated so idle outputs stay low.
   always_comb begin
      bus.in_ready   = (state == StFill);
      bus.spad_wen   = in_hs;
      bus.spad_waddr = wptr;
      bus.spad_din   = (state == StFill) ? bus.in_data : '0;
      bus.spad_raddr = rptr;
      bus.out_valid  = (state == StDrain);
      bus.out_data   = (state == StDrain) ? bus.spad_dout : '0;
      bus.out_last   = (state == StDrain) && rd_end && final_pass;
      bus.busy       = (state == StFill) || (state == StDrain);
      bus.done       = (state == StDone);
   end
endmodule

// File: tb/tb_spad_seq_ctrl.sv
// Scoreboard bench for spad_seq_ctrl: random jobs, random stalls, reference queue of beats.
module tb_spad_seq_ctrl;
   localparam int unsigned DW = 16;
   localparam int unsigned NR = 9;
   localparam int unsigned AW = $clog2(NR);

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   spad_seq_ctrl_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) bus ();

   spad_seq_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Scratchpad model: synchronous write, combinational read.
   logic [DW-1:0] mem [NR];
   initial for (int i = 0; i < int'(NR); i++) mem[i] = '0;
   always @(posedge clk) if (bus.spad_wen) mem[bus.spad_waddr] <= bus.spad_din;
   assign bus.spad_dout = (int'(bus.spad_raddr) < int'(NR)) ? mem[bus.spad_raddr] : 16'hDEAD;

   beat_t  exp_q[$];
   int     n_vec = 0;
   int     n_err = 0;
   int     beats = 0;
   int     rprob = 100;
   bit     done_due = 1'b0;
   bit     job_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Downstream ready generator.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.out_ready = ($urandom_range(0, 99) < rprob);
      end
   end

   // Monitor: pops the scoreboard on every downstream handshake, checks done and stall hold.
   initial begin
      beat_t         e;
      bit            stalled = 1'b0;
      logic [DW-1:0] held = '0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            chk("done", 32'(bus.done), 32'(done_due));
            if (done_due && bus.done) job_done = 1'b1;
            done_due = 1'b0;
            chk("wen", 32'(bus.spad_wen), 32'(bus.in_valid & bus.in_ready));
            chk("busy", 32'(bus.busy), 32'(bus.in_ready | bus.out_valid));
            if (stalled && bus.out_valid) chk("stall_hold", 32'(bus.out_data), 32'(held));
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
               beats++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", 32'(bus.out_data), 32'(e.data));
                  chk("out_last", 32'(bus.out_last), 32'(e.last));
                  if (e.last) done_due = 1'b1;
               end
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // Issue a job and feed its operands; expected beats go to the scoreboard up front.
   task automatic issue_fill(input int len_in, input int passes_in, input int vprob,
                             input bit start_mid);
      int            n;
      int            np;
      int            i;
      int            cyc;
      logic [DW-1:0] d[$];
      n  = (len_in > int'(NR)) ? int'(NR) : len_in;
      np = 1;
`ifdef SPAD_SEQ_REUSE_EN
      np = (passes_in == 0) ? 1 : passes_in;
`endif
      for (int k = 0; k < n; k++) d.push_back(16'($urandom));
      for (int p = 0; p < np; p++)
         for (int k = 0; k < n; k++)
            exp_q.push_back('{data: d[k], last: (p == np - 1) && (k == n - 1)});
      job_done = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.len   = (AW + 1)'(len_in);
`ifdef SPAD_SEQ_REUSE_EN
      bus.passes = 4'(passes_in);
`endif
      @(posedge clk);
      #1 bus.start = 1'b0;
      i   = 0;
      cyc = 0;
      while (i < n && cyc < 1000) begin
         bus.in_valid = ($urandom_range(0, 99) < vprob);
         bus.in_data  = d[i];
         bus.start    = start_mid && (cyc == 1);
         if (bus.start) bus.len = (AW + 1)'(2);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) begin
            chk("waddr", 32'(bus.spad_waddr), 32'(i));
            chk("din", 32'(bus.spad_din), 32'(d[i]));
            i++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      if (cyc >= 1000) chk("fill_timeout", 32'd0, 32'd1);
      if (n > 0) begin
         @(negedge clk);
         chk("drain_latency", 32'(bus.out_valid), 32'd1);
      end
   endtask

   task automatic wait_done();
      for (int c = 0; c < 3000 && !job_done; c++) @(negedge clk);
      chk("job_done", 32'(job_done), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic run_job(input int len_in, input int passes_in, input int vprob);
      issue_fill(len_in, passes_in, vprob, 1'b0);
      wait_done();
   endtask

   initial begin
      int b0;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
`ifdef SPAD_SEQ_REUSE_EN
      bus.passes   = '0;
`endif
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_wen", 32'(bus.spad_wen), 32'd0);
      chk("rst_waddr", 32'(bus.spad_waddr), 32'd0);
      chk("rst_raddr", 32'(bus.spad_raddr), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
      #22 rstn = 1'b1;

      // Directed: basic, full depth, clamp, ignored zero-length start.
      rprob = 100;
      run_job(3, 1, 100);
      run_job(9, 1, 100);
      rprob = 60;
      run_job(4, 1, 50);
      run_job(12, 1, 70);
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.len = '0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("len0_busy", 32'(bus.busy), 32'd0);
         chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
      end

      // Start pulsed during FILL must not alter the running job.
      issue_fill(6, 1, 60, 1'b1);
      wait_done();

      // Reset in the middle of DRAIN.
      rprob = 100;
      issue_fill(5, 1, 100, 1'b0);
      b0 = beats;
      for (int c = 0; c < 200 && beats == b0; c++) @(negedge clk);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_wen", 32'(bus.spad_wen), 32'd0);
      chk("mid_rst_raddr", 32'(bus.spad_raddr), 32'd0);
      exp_q.delete();
      done_due = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      run_job(2, 1, 100);

`ifdef SPAD_SEQ_REUSE_EN
      run_job(2, 3, 100);
      run_job(3, 0, 100);
`endif

      // Random jobs with random stalls on both sides.
      for (int j = 0; j < 20; j++) begin
         rprob = $urandom_range(30, 100);
         run_job($urandom_range(0, 12) == 0 ? 1 : $urandom_range(1, 12),
                 $urandom_range(0, 4), $urandom_range(30, 100));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
